// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common_pkg
//  Description : Shared writeback request type and the round-robin pick
//                helper used by the register-file writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package common_pkg;

  // Default register index / data widths of the writeback request record.
  localparam int c_wb_addr_width = 5;
  localparam int c_wb_data_width = 32;

  // Widest requester vector the round-robin helper can scan.
  localparam int c_rr_max_sources = 32;
  localparam int c_rr_idx_w       = 5;

  typedef struct packed {
    logic [c_wb_addr_width-1:0] addr;
    logic [c_wb_data_width-1:0] data;
  } wb_req_t;

  // First set bit of req[n-1:0] found by scanning upward from ptr with
  // wrap-around; -1 when no bit is set. ptr must be below n.
  function automatic int rr_pick(input logic [c_rr_max_sources-1:0] req,
                                 input int ptr,
                                 input int n);
    int pick;
    int idx;
    pick = -1;
    idx  = 0;
    for (int k = 0; k < c_rr_max_sources; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (pick < 0 && req[idx[c_rr_idx_w-1:0]]) begin
          pick = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_write_interface
//  Description : Register-file write port bundle (enable, index, data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_write_interface #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  // Driven by the arbiter.
  modport write (output wen, output addr, output data);
  // Observed by the register file.
  modport read  (input wen, input addr, input data);
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : One-hot round-robin grant over SOURCES requesters. The
//                search starts at an internal pointer which moves to one past
//                the granted index whenever a grant is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import common_pkg::*;
#(
  parameter int SOURCES = 3
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [SOURCES-1:0] i_req,
  output logic      [SOURCES-1:0] o_grant
);

  localparam int c_ptr_w = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  logic [c_ptr_w-1:0]          r_rr;
  logic [c_rr_max_sources-1:0] w_req_ext;
  int                          w_pick;

  assign w_req_ext = c_rr_max_sources'(i_req);

  // Locate the winning requester for this cycle.
  always_comb begin
    w_pick = rr_pick(w_req_ext, int'(r_rr), SOURCES);
  end

  generate
    for (genvar i = 0; i < SOURCES; i++) begin : g_grant
      assign o_grant[i] = (w_pick == i);
    end
  endgenerate

  // Advance the search start past the winner; hold it when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_pick >= 0) begin
      r_rr <= (w_pick == SOURCES - 1) ? '0 : c_ptr_w'(w_pick + 1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Collects writeback requests from SOURCES producers into one
//                pending slot each and drains them one per cycle, round-robin,
//                onto a single register-file write port. Same-address requests
//                are held back so write-after-write order is preserved, and
//                pending data is exposed through a forwarding lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import common_pkg::*;
#(
  parameter int SOURCES    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  input  wire logic [SOURCES-1:0]                  req_valid,
  input  wire logic [SOURCES-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  wire logic [SOURCES-1:0][DATA_WIDTH-1:0]  req_data,
  output logic      [SOURCES-1:0]                  req_ready,
  data_write_interface.write                       wr,
  input  wire logic [ADDR_WIDTH-1:0]               fwd_addr,
  output logic                                     fwd_hit,
  output logic      [DATA_WIDTH-1:0]               fwd_data,
  output logic                                     idle
);

  // Pending slot per source.
  logic [SOURCES-1:0]                 r_occ;
  logic [SOURCES-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [SOURCES-1:0][DATA_WIDTH-1:0] r_data;

  logic [SOURCES-1:0]    w_grant;
  logic [SOURCES-1:0]    w_conflict;
  logic [SOURCES-1:0]    w_accept;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  rr_arbiter #(
    .SOURCES (SOURCES)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (r_occ),
    .o_grant (w_grant)
  );

  // Accept a source when its slot is free or draining this cycle and no
  // other write to the same register is still in flight or being accepted
  // by a lower-index source; address 0 never conflicts.
  always_comb begin
    w_conflict = '0;
    req_ready  = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (req_addr[i] != '0) begin
        for (int j = 0; j < SOURCES; j++) begin
          if (j != i && r_occ[j] && !w_grant[j] && r_addr[j] == req_addr[i]) begin
            w_conflict[i] = 1'b1;
          end
          if (j < i && req_valid[j] && req_ready[j] && req_addr[j] == req_addr[i]) begin
            w_conflict[i] = 1'b1;
          end
        end
      end
      req_ready[i] = (~r_occ[i] | w_grant[i]) & ~w_conflict[i];
    end
  end

  assign w_accept = req_valid & req_ready;

  // Load accepted requests (address 0 is dropped) and retire granted slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      for (int i = 0; i < SOURCES; i++) begin
        if (w_accept[i]) begin
          r_occ[i]  <= (req_addr[i] != '0);
          r_addr[i] <= req_addr[i];
          r_data[i] <= req_data[i];
        end else if (w_grant[i]) begin
          r_occ[i] <= 1'b0;
        end
      end
    end
  end

  // Route the granted slot to the write port; all-zero when nothing drains.
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (w_grant[i]) begin
        w_wr_addr = w_wr_addr | r_addr[i];
        w_wr_data = w_wr_data | r_data[i];
      end
    end
  end

  assign wr.wen  = |r_occ;
  assign wr.addr = w_wr_addr;
  assign wr.data = w_wr_data;

  // Forward from pending slots only; at most one slot can match a nonzero
  // address, so OR-combining the matches yields that slot's data.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      for (int j = 0; j < SOURCES; j++) begin
        if (r_occ[j] && r_addr[j] == fwd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = fwd_data | r_data[j];
        end
      end
    end
  end

  assign idle = ~|r_occ;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter: directed
//                scenarios with literal expectations followed by random
//                traffic checked every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  import common_pkg::*;

  localparam int S  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [S-1:0]         req_valid;
  logic [S-1:0][AW-1:0] req_addr;
  logic [S-1:0][DW-1:0] req_data;
  logic [S-1:0]         req_ready;
  logic [AW-1:0]        fwd_addr;
  logic                 fwd_hit;
  logic [DW-1:0]        fwd_data;
  logic                 idle;

  data_write_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_if ();

  regfile_wb_arbiter #(
    .SOURCES    (S),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr        (wr_if),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each source owns at most one pending write; writes drain one per cycle
  // starting the search at m_rr.
  logic    m_occ [S];
  wb_req_t m_ent [S];
  int      m_rr;
  logic [DW-1:0] rf_model [32] = '{default: '0};
  logic [DW-1:0] rf_seen  [32] = '{default: '0};
  int      wr_count = 0;

  int            e_grant;
  logic [S-1:0]  e_ready;
  logic          e_wen;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic          e_hit;
  logic [DW-1:0] e_fdata;
  logic          e_idle;
  logic          e_claimed;

  always_comb begin
    e_grant = -1;
    for (int k = 0; k < S; k++) begin
      if (e_grant < 0 && m_occ[(m_rr + k) % S]) e_grant = (m_rr + k) % S;
    end
    e_wen   = (e_grant >= 0);
    e_waddr = '0;
    e_wdata = '0;
    if (e_grant >= 0) begin
      e_waddr = m_ent[e_grant].addr;
      e_wdata = m_ent[e_grant].data;
    end
    // A register is claimed if a write to it stays pending past this cycle
    // or an earlier source is handing one over right now.
    e_ready   = '0;
    e_claimed = 1'b0;
    for (int i = 0; i < S; i++) begin
      e_claimed = 1'b0;
      if (req_addr[i] != '0) begin
        for (int j = 0; j < S; j++) begin
          if (j != i && m_occ[j] && j != e_grant && m_ent[j].addr == req_addr[i]) e_claimed = 1'b1;
          if (j < i && req_valid[j] && e_ready[j] && req_addr[j] == req_addr[i]) e_claimed = 1'b1;
        end
      end
      e_ready[i] = !(m_occ[i] && i != e_grant) && !e_claimed;
    end
    e_hit   = 1'b0;
    e_fdata = '0;
    for (int j = 0; j < S; j++) begin
      if (fwd_addr != '0 && m_occ[j] && m_ent[j].addr == fwd_addr) begin
        e_hit   = 1'b1;
        e_fdata = m_ent[j].data;
      end
    end
    e_idle = 1'b1;
    for (int j = 0; j < S; j++) if (m_occ[j]) e_idle = 1'b0;
  end

  // Model state update.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S; i++) m_occ[i] <= 1'b0;
      m_rr <= 0;
    end else begin
      if (e_grant >= 0) begin
        rf_model[m_ent[e_grant].addr] <= m_ent[e_grant].data;
        m_rr <= (e_grant + 1) % S;
      end
      for (int i = 0; i < S; i++) begin
        if (req_valid[i] && e_ready[i]) begin
          m_occ[i] <= (req_addr[i] != '0);
          m_ent[i] <= '{addr: req_addr[i], data: req_data[i]};
        end else if (i == e_grant) begin
          m_occ[i] <= 1'b0;
        end
      end
    end
  end

  // Register file as seen through the DUT write port.
  always @(posedge clk) begin
    if (!rst && wr_if.wen) begin
      rf_seen[wr_if.addr] <= wr_if.data;
      wr_count <= wr_count + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_ready", req_ready, e_ready);
      chk("cyc_wen", wr_if.wen, e_wen);
      chk("cyc_waddr", wr_if.addr, e_waddr);
      chk("cyc_wdata", wr_if.data, e_wdata);
      chk("cyc_fwd_hit", fwd_hit, e_hit);
      chk("cyc_fwd_data", fwd_data, e_fdata);
      chk("cyc_idle", idle, e_idle);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic put(input logic [1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[s] = 1'b1;
    req_addr[s]  = a;
    req_data[s]  = d;
  endtask

  task automatic next_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic next_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int base_count;

  initial begin
    clear_inputs();
    fwd_addr = '0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    fwd_addr = 5'd3;
    repeat (2) @(posedge clk);
    checking = 1'b1;
    // Outputs while held in reset.
    next_neg();
    chk("rst_ready", req_ready, 3'b111);
    chk("rst_wen", wr_if.wen, 1'b0);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    chk("rst_fwd_data", fwd_data, 32'h0);
    chk("rst_idle", idle, 1'b1);
    next_pos();
    rst = 1'b0;
    // First cycle after release.
    next_neg();
    chk("post_rst_ready", req_ready, 3'b111);
    chk("post_rst_wen", wr_if.wen, 1'b0);
    chk("post_rst_idle", idle, 1'b1);
    next_pos();

    // Single uncontended write: one cycle latency, then idle.
    put(2'd0, 5'd3, 32'hAAAA_0001);
    next_neg();
    chk("t1_ready", req_ready[0], 1'b1);
    chk("t1_wen_pre", wr_if.wen, 1'b0);
    next_pos();
    clear_inputs();
    next_neg();
    chk("t1_wen", wr_if.wen, 1'b1);
    chk("t1_addr", wr_if.addr, 5'd3);
    chk("t1_data", wr_if.data, 32'hAAAA_0001);
    chk("t1_busy", idle, 1'b0);
    next_pos();
    next_neg();
    chk("t1_idle", idle, 1'b1);
    chk("t1_wen_post", wr_if.wen, 1'b0);
    next_pos();

    // Three simultaneous writes from rr = 0 drain in source order; a second
    // round draining in the same order shows the pointer wrapped to 0.
    do_reset();
    for (int round = 0; round < 2; round++) begin
      for (int s = 0; s < S; s++) begin
        put(2'(s), 5'(1 + 3 * round + s), 32'(32'h100 * (1 + 3 * round + s)));
      end
      next_neg();
      chk("t2_ready", req_ready, 3'b111);
      next_pos();
      clear_inputs();
      for (int k = 0; k < S; k++) begin
        next_neg();
        chk("t2_order_addr", wr_if.addr, 5'(1 + 3 * round + k));
        chk("t2_order_wen", wr_if.wen, 1'b1);
        next_pos();
      end
      next_neg();
      chk("t2_idle", idle, 1'b1);
      next_pos();
    end

    // Same-address hazard: src2 must wait until src1's write to 5 drains.
    put(2'd0, 5'd9, 32'h90);
    put(2'd1, 5'd5, 32'h51);
    put(2'd2, 5'd5, 32'h52);
    next_neg();
    chk("t3_ready_a", req_ready, 3'b011);
    next_pos();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    next_neg();
    chk("t3_wr_b", wr_if.addr, 5'd9);
    chk("t3_ready_b", req_ready, 3'b001);
    next_pos();
    next_neg();
    chk("t3_wr_c_addr", wr_if.addr, 5'd5);
    chk("t3_wr_c_data", wr_if.data, 32'h51);
    chk("t3_ready_c", req_ready, 3'b111);
    next_pos();
    clear_inputs();
    next_neg();
    chk("t3_wr_d_addr", wr_if.addr, 5'd5);
    chk("t3_wr_d_data", wr_if.data, 32'h52);
    next_pos();
    next_neg();
    chk("t3_idle", idle, 1'b1);
    chk("t3_final", rf_seen[5], 32'h52);
    next_pos();

    // Address 0 is accepted but never written.
    put(2'd0, 5'd0, 32'hDEAD);
    next_neg();
    chk("t4_ready", req_ready[0], 1'b1);
    next_pos();
    clear_inputs();
    next_neg();
    chk("t4_wen", wr_if.wen, 1'b0);
    chk("t4_idle", idle, 1'b1);
    next_pos();

    // Forwarding from a pending slot, not from the accepting request.
    fwd_addr = 5'd7;
    put(2'd0, 5'd7, 32'h1234);
    next_neg();
    chk("t5_fwd_same_cycle", fwd_hit, 1'b0);
    next_pos();
    clear_inputs();
    next_neg();
    chk("t5_hit", fwd_hit, 1'b1);
    chk("t5_data", fwd_data, 32'h1234);
    fwd_addr = 5'd8;
    #1;
    chk("t5_miss_hit", fwd_hit, 1'b0);
    chk("t5_miss_data", fwd_data, 32'h0);
    next_pos();

    // Mid-cycle reset with three pending writes discards them all.
    put(2'd0, 5'd10, 32'hA0);
    put(2'd1, 5'd11, 32'hB0);
    put(2'd2, 5'd12, 32'hC0);
    next_pos();
    clear_inputs();
    #2;
    chk("t6_pending", idle, 1'b0);
    base_count = wr_count;
    rst = 1'b1;
    #1;
    chk("t6_wen", wr_if.wen, 1'b0);
    chk("t6_idle", idle, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (5) next_pos();
    chk("t6_no_writes", 64'(wr_count - base_count), 64'd0);

    // Random traffic over a small address range to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        clear_inputs();
        #2;
        rst = 1'b1;
        #4;
        rst = 1'b0;
        next_pos();
      end
      for (int s = 0; s < S; s++) begin
        req_valid[s] = ($urandom_range(0, 9) < 6);
        req_addr[s]  = 5'($urandom_range(0, 7));
        req_data[s]  = $urandom;
      end
      fwd_addr = 5'($urandom_range(0, 8));
      next_pos();
    end
    clear_inputs();
    repeat (S + 2) next_pos();
    chk("final_idle", idle, 1'b1);
    for (int a = 0; a < 32; a++) begin
      chk("final_regfile", rf_seen[a], rf_model[a]);
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
